// File: rtl/alu_pkg.sv
// Shared ALU opcode constants, polynomials and sequencer state encoding for the
// ALU self-test sequencer.
package alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_AND  = 4'b0111;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_MUL  = 4'b1111;
    localparam logic [3:0] ALU_SRAI = 4'b1101;
    localparam logic [3:0] ALU_NOP  = 4'b0010;

    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
    localparam logic [31:0] MISR_POLY = 32'h04C1_1DB7;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_APPLY = 2'd1,
        S_STEP  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Opcode for vector index k, selected by k mod 8.
    function automatic logic [3:0] op_for(input logic [2:0] k);
        logic [3:0] op;
        case (k)
            3'd0:    op = ALU_ADD;
            3'd1:    op = ALU_SUB;
            3'd2:    op = ALU_AND;
            3'd3:    op = ALU_XOR;
            3'd4:    op = ALU_SLL;
            3'd5:    op = ALU_MUL;
            3'd6:    op = ALU_SRAI;
            default: op = ALU_NOP;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/lfsr32_step.sv
// One combinational step of the 32-bit right-shifting Galois operand LFSR.
module lfsr32_step
    import alu_pkg::*;
(
    input  logic [31:0] state,
    output logic [31:0] next
);

    assign next = (state >> 1) ^ (state[0] ? LFSR_POLY : 32'h0);

endmodule

// File: rtl/alu_bist.sv
// ALU self-test sequencer: drives LFSR operands and a rotating opcode into the
// ALU, and folds each result/zero pair into a 32-bit MISR signature.
module alu_bist
    import alu_pkg::*;
#(
    parameter int unsigned NUM_VECTORS = 64,
    parameter logic [31:0] LFSR_SEED   = 32'h0000_0001,
    parameter logic [31:0] MISR_SEED   = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    output logic [31:0] a_o,
    output logic [31:0] b_o,
    output logic [3:0]  aluctr_o,
    input  logic [31:0] result_i,
    input  logic        zero_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] signature_o,
    output logic [15:0] vec_count_o
);

    state_t      state, state_n;
    logic [31:0] lfsr;
    logic        load_first, load_next, capture;
    logic [31:0] src, nxt, nxt2;
    logic [3:0]  op;
    logic [31:0] b_val, misr_n;
    logic        last;

    // A new run always restarts from the seed; otherwise continue the sequence.
    assign src   = load_first ? LFSR_SEED : lfsr;
    assign op    = op_for(load_first ? 3'd0 : vec_count_o[2:0]);
    assign b_val = (op == ALU_SLL || op == ALU_SRAI) ? {27'b0, nxt[4:0]} : nxt;
    assign last  = (vec_count_o + 16'd1) == 16'(NUM_VECTORS);

    assign misr_n = {signature_o[30:0], 1'b0}
                  ^ (signature_o[31] ? MISR_POLY : 32'h0)
                  ^ result_i ^ {zero_i, 31'b0};

    lfsr32_step u_step1 (.state(src), .next(nxt));
    lfsr32_step u_step2 (.state(nxt), .next(nxt2));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state <= S_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n    = state;
        load_first = 1'b0;
        load_next  = 1'b0;
        capture    = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    load_first = 1'b1;
                    state_n    = S_APPLY;
                end
            end
            S_APPLY: begin
                capture = 1'b1;
                state_n = last ? S_DONE : S_STEP;
            end
            S_STEP: begin
                load_next = 1'b1;
                state_n   = S_APPLY;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            lfsr        <= LFSR_SEED;
            a_o         <= '0;
            b_o         <= '0;
            aluctr_o    <= '0;
            signature_o <= '0;
            vec_count_o <= '0;
            done_o      <= 1'b0;
        end else begin
            if (load_first || load_next) begin
                a_o      <= src;
                b_o      <= b_val;
                aluctr_o <= op;
                lfsr     <= nxt2;
            end
            if (load_first) begin
                signature_o <= MISR_SEED;
                vec_count_o <= '0;
                done_o      <= 1'b0;
            end
            if (capture) begin
                signature_o <= misr_n;
                vec_count_o <= vec_count_o + 16'd1;
                if (last) done_o <= 1'b1;
            end
        end
    end

    assign busy_o = (state == S_APPLY) || (state == S_STEP);

endmodule

// File: doc/alu_bist.md
# alu_bist

Self-test sequencer that is the driving end of the ALU operand/opcode interface. It generates pseudo-random operand pairs, cycles through every ALU operation code, samples the ALU's result and zero flag, and compresses them into a 32-bit MISR signature. It sits beside the CPU datapath ALU behind a mux on the ALU inputs and is used at bring-up and in regression to check the ALU against a golden signature.

## Interface
- NUM_VECTORS, 64: vectors applied per run; legal range 1..65535.
- LFSR_SEED, 32'h0000_0001: operand LFSR seed; must be nonzero.
- MISR_SEED, 32'h0000_0000: signature start value.
- clk_i  in  1  clock; single clock domain, all state on rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- start_i  in  1  one-cycle run request.
- a_o  out  32  ALU operand A.
- b_o  out  32  ALU operand B.
- aluctr_o  out  4  ALU operation code.
- result_i  in  32  ALU result, combinational from a_o/b_o/aluctr_o.
- zero_i  in  1  ALU zero flag.
- busy_o  out  1  run in progress.
- done_o  out  1  run complete; sticky until next start or reset.
- signature_o  out  32  MISR value.
- vec_count_o  out  16  vectors captured in the current run.

## Operation
- States: IDLE, APPLY, STEP, DONE.
- IDLE/DONE + start_i: load vector 0, signature <= MISR_SEED, vec_count <= 0, done <= 0 -> APPLY.
- APPLY: outputs stable for the whole cycle; at the closing edge the MISR absorbs result_i/zero_i and vec_count increments. Go to DONE if vec_count+1 == NUM_VECTORS, else STEP.
- STEP: at the closing edge, load the next vector -> APPLY.
- Operand LFSR: Galois, right-shift: next = (s >> 1) ^ (s[0] ? 32'h8020_0003 : 0).
  - Per vector: a_o = s, b_o = next(s); the stored state then advances two steps.
- Shift operations mask b: for codes 0001 and 1101, b_o = {27'b0, next(s)[4:0]}.
- Opcode for vector k is selected by k mod 8, in this order: 0000 add, 1000 sub, 0111 and, 0100 xor, 0001 sll, 1111 mul, 1101 srai, 0010 (unused code; the ALU must return 0 with zero=1).
- MISR: sig <= {sig[30:0], 1'b0} ^ (sig[31] ? 32'h04C1_1DB7 : 0) ^ result_i ^ {zero_i, 31'b0}.
- start_i while busy_o=1 is ignored.
- In DONE, all outputs hold their values; start_i restarts the run from the seed.

## Timing
- Reset values: a_o=0, b_o=0, aluctr_o=0, busy_o=0, done_o=0, signature_o=0, vec_count_o=0, state IDLE. The LFSR state resets to LFSR_SEED.
- Reset asserted mid-run aborts the run immediately (asynchronous) and all outputs take their reset values.
- start_i sampled at edge t0: vector 0 is on the outputs and busy_o=1 from t0.
- Each vector occupies 2 cycles; no pipelining with the ALU, which is a combinational path only.
- Final capture happens at edge t0+2N-1. At that edge: done_o=1, busy_o=0, vec_count_o=N, final signature_o.
- busy_o and done_o are never both 1.
- vec_count_o and signature_o update only at APPLY closing edges.

## Structure
- Shared package alu_pkg:
  - ALU opcode constants ALU_ADD, ALU_SUB, ALU_AND, ALU_XOR, ALU_SLL, ALU_MUL, ALU_SRAI, ALU_NOP=4'b0010.
  - LFSR_POLY, MISR_POLY.
  - State enum.
- One sub-module, lfsr32_step: combinational single Galois step, instantiated twice (next and next-next).
- The MISR update and opcode table stay inline.

## Test plan
- Reset, then start with LFSR_SEED=1, N=64 -> vector 0: a_o=0x0000_0001, b_o=0x8020_0003, aluctr_o=0000. Vector 1: a_o=0xC030_0002, aluctr_o=1000.
- Stub ALU (result=0, zero=1), N=1, MISR_SEED=0 -> done_o at t0+1, signature_o=0x8000_0000, vec_count_o=1.
- Same stub, N=2 -> done_o at t0+3, signature_o=0x84C1_1DB7.
- Real ALU, N=64 -> signature matches the reference-model value. Also check: busy_o high for exactly 127 cycles, and aluctr_o sequence repeats every 8 vectors.
- Pulse start_i during the run at vector 10 -> no effect, identical signature. Assert rst_i at vector 10 -> all outputs 0 in the same cycle; a fresh start reproduces the golden signature.
- Start in DONE -> done_o clears, vector 0 reloaded; a vector 7 (0010) pulled from a real ALU captures result 0, zero 1.
